stb_sample_seq: RTL and testbench
=================================

STB_SAMPLE_SEQ -- requirements
Module: stb_sample_seq

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, meaning width of the sample count and hit count.
REQ-002 SHALL have parameter TMO_WIDTH, default 24, meaning width of the per-strobe timeout counter (limit 2**TMO_WIDTH-1 cycles).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles from strobe-valid edge to comparator sample.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; arstn_i  in  1  async active-low reset.
REQ-005 SHALL have start_i  in  1  one-cycle start pulse.
REQ-006 SHALL have n_samples_i  in  CNT_WIDTH  strobes per run, sampled on start.
REQ-007 SHALL have stb_rdy_i  in  1  strobe generator locked (rdy).
REQ-008 SHALL have stb_valid_i  in  1  strobe output valid.
REQ-009 SHALL have stb_req_o  out  1  strobe request to generator (rising edge = request).
REQ-010 SHALL have cmp_i  in  1  asynchronous comparator output.
REQ-011 SHALL have busy_o  out  1  run in progress.
REQ-012 SHALL have done_o  out  1  one-cycle end-of-run pulse.
REQ-013 SHALL have hits_o  out  CNT_WIDTH  comparator-high count for the last run.
REQ-014 SHALL have err_o  out  2  run status: 00 ok, 01 timeout, 10 generator not ready.

Function
REQ-015 SHALL synchronise cmp_i through two flops before use; stb_valid_i and stb_rdy_i are same-clock, unsynchronised.
REQ-016 SHALL implement states IDLE, REQ_LOW, REQ_HIGH, WAIT_VALID, SETTLE, SAMPLE, DONE.
REQ-017 SHALL in IDLE on start_i: if stb_rdy_i=0, go DONE with err=10 and hits=0; else if n_samples_i=0, go DONE with err=00 and hits=0; else latch remaining=n_samples_i, clear hits and err, go REQ_LOW.
REQ-018 SHALL ignore start_i in every state other than IDLE.
REQ-019 SHALL drive stb_req_o=0 in REQ_LOW for exactly one cycle, then go REQ_HIGH.
REQ-020 SHALL drive stb_req_o=1 in REQ_HIGH, WAIT_VALID, SETTLE and SAMPLE, and 0 in all other states.
REQ-021 SHALL stay in REQ_HIGH one cycle, clear the timeout counter, then go WAIT_VALID.
REQ-022 SHALL in WAIT_VALID advance to SETTLE only on a stb_valid_i rising edge (registered previous value); a level already high on entry SHALL NOT count.
REQ-023 SHALL in WAIT_VALID increment the timeout counter each cycle; at terminal count it SHALL go DONE with err=01, keeping hits accumulated so far.
REQ-024 SHALL count SETTLE_CYCLES cycles in SETTLE, then go SAMPLE.
REQ-025 SHALL in SAMPLE (one cycle) add the synchronised comparator bit to hits and decrement remaining; it SHALL go DONE if remaining was 1, else REQ_LOW.
REQ-026 SHALL in DONE pulse done_o for one cycle, update hits_o and err_o, then return to IDLE.
REQ-027 SHALL assert busy_o in every state except IDLE.
REQ-028 SHALL hold hits_o and err_o stable from one DONE until the next DONE.
REQ-029 SHALL use a hits counter that cannot overflow, since hits never exceeds n_samples.
REQ-030 SHALL return to IDLE with stb_req_o low if stb_rdy_i falls mid-run, only through timeout (no other abort path).

Reset
REQ-031 SHALL on arstn_i low asynchronously force IDLE, stb_req_o=0, busy_o=0, done_o=0, hits_o=0, err_o=00, and clear all counters and synchroniser flops.
REQ-032 SHALL abandon an in-progress run on reset assertion without producing done_o.

Structure
REQ-033 SHALL place the state enum and the err code constants (ERR_OK, ERR_TMO, ERR_NRDY) in package meas_pkg.
REQ-034 SHALL instantiate the existing sync_ff (WIDTH=1, STAGES=2) for cmp_i; no other sub-module.

Verification
REQ-035 SHALL cover: rdy=1, n=3, valid edge 10 cycles after each req edge, cmp=1,0,1 -> done after 3 samples, hits=2, err=00.
REQ-036 SHALL cover: start with stb_rdy_i=0 -> done_o one cycle later, hits=0, err=10, stb_req_o never high.
REQ-037 SHALL cover: n=0 -> done_o, hits=0, err=00, no request issued.
REQ-038 SHALL cover: TMO_WIDTH=4, valid never rises -> done after 15 wait cycles, err=01, hits=0.
REQ-039 SHALL cover: stb_valid_i held high before the request -> no sample until valid drops and rises again.
REQ-040 SHALL cover: reset asserted during SETTLE of sample 2 -> immediate IDLE, req low, no done_o; a new start then runs cleanly.

Source files
------------

// File: rtl/meas_pkg.sv
// meas_pkg: sequencer state encoding and run-status codes shared by the
// strobe sampling sequencer and its environment.
package meas_pkg;
   typedef enum logic [2:0] {
      IDLE,
      REQ_LOW,
      REQ_HIGH,
      WAIT_VALID,
      SETTLE,
      SAMPLE,
      DONE
   } seq_state_e;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_TMO  = 2'b01;
   localparam logic [1:0] ERR_NRDY = 2'b10;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop synchroniser for signals from another clock
// domain.
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk_i or negedge arstn_i)
      if (!arstn_i) stage_q <= '0;
      else          stage_q <= {stage_q[STAGES-2:0], d_i};

   assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/stb_sample_seq.sv
// stb_sample_seq: requests strobes from a generator, waits for each strobe
// to become valid and settle, then samples a comparator and counts its hits.
module stb_sample_seq
   import meas_pkg::*;
#(
   parameter int CNT_WIDTH     = 16,
   parameter int TMO_WIDTH     = 24,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk_i,
   input  logic                 arstn_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] n_samples_i,
   input  logic                 stb_rdy_i,
   input  logic                 stb_valid_i,
   output logic                 stb_req_o,
   input  logic                 cmp_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] hits_o,
   output logic [1:0]           err_o
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   // The wait that starts at zero times out on its (2**TMO_WIDTH-1)th cycle.
   localparam logic [TMO_WIDTH-1:0] TMO_LAST    = {{(TMO_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   seq_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [CNT_WIDTH-1:0] hits_q, hits_d;
   logic [CNT_WIDTH-1:0] hits_out_q;
   logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic [1:0]           err_d, err_out_q;
   logic                 valid_prev_q;
   logic                 cmp_s;
   logic                 valid_rise;

   sync_ff #(.WIDTH(1), .STAGES(2)) u_cmp_sync (
      .clk_i  (clk_i),
      .arstn_i(arstn_i),
      .d_i    (cmp_i),
      .q_o    (cmp_s)
   );

   assign valid_rise = stb_valid_i & ~valid_prev_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      hits_d      = hits_q;
      tmo_d       = tmo_q;
      settle_d    = settle_q;
      err_d       = ERR_OK;
      case (state_q)
         IDLE:
            if (start_i) begin
               hits_d = '0;
               if (!stb_rdy_i) begin
                  state_d = DONE;
                  err_d   = ERR_NRDY;
               end else if (n_samples_i == '0) begin
                  state_d = DONE;
               end else begin
                  remaining_d = n_samples_i;
                  state_d     = REQ_LOW;
               end
            end
         REQ_LOW:  state_d = REQ_HIGH;
         REQ_HIGH: begin
            tmo_d   = '0;
            state_d = WAIT_VALID;
         end
         WAIT_VALID: begin
            tmo_d    = tmo_q + 1'b1;
            settle_d = '0;
            if (valid_rise) state_d = SETTLE;
            else if (tmo_q == TMO_LAST) begin
               state_d = DONE;
               err_d   = ERR_TMO;
            end
         end
         SETTLE: begin
            settle_d = settle_q + 1'b1;
            state_d  = (settle_q == SETTLE_LAST) ? SAMPLE : SETTLE;
         end
         SAMPLE: begin
            hits_d      = hits_q + {{(CNT_WIDTH-1){1'b0}}, cmp_s};
            remaining_d = remaining_q - 1'b1;
            state_d     = (remaining_q == CNT_WIDTH'(1)) ? DONE : REQ_LOW;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result registers load on entry to DONE so they are valid with done_o.
   always_ff @(posedge clk_i or negedge arstn_i)
      if (!arstn_i) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         hits_q       <= '0;
         tmo_q        <= '0;
         settle_q     <= '0;
         valid_prev_q <= 1'b0;
         hits_out_q   <= '0;
         err_out_q    <= ERR_OK;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         hits_q       <= hits_d;
         tmo_q        <= tmo_d;
         settle_q     <= settle_d;
         valid_prev_q <= stb_valid_i;
         if (state_d == DONE) begin
            hits_out_q <= hits_d;
            err_out_q  <= err_d;
         end
      end

   assign busy_o    = state_q != IDLE;
   assign done_o    = state_q == DONE;
   assign stb_req_o = state_q inside {REQ_HIGH, WAIT_VALID, SETTLE, SAMPLE};
   assign hits_o    = hits_out_q;
   assign err_o     = err_out_q;
endmodule

// File: tb/tb_stb_sample_seq.sv
// tb_stb_sample_seq: directed and randomized checks of stb_sample_seq against
// a timeline model of each run.
module tb_stb_sample_seq;
   import meas_pkg::*;

   localparam int CW      = 16;
   localparam int TW      = 4;
   localparam int SC      = 4;
   localparam int TMO_LIM = 2**TW - 1;
   localparam int VM_SCHED = 0, VM_LOW = 1, VM_HIGH = 2, VM_RAND = 3;

   logic          clk = 1'b0;
   logic          arstn_i = 1'b1;
   logic          start_i = 1'b0;
   logic          stb_rdy_i = 1'b0;
   logic          stb_valid_i;
   logic          cmp_i;
   logic [CW-1:0] n_samples_i = '0;
   logic          stb_req_o, busy_o, done_o;
   logic [CW-1:0] hits_o;
   logic [1:0]    err_o;

   int checks = 0;
   int failures = 0;
   int vmode = VM_SCHED;
   int vdly = 10;
   int cmode = 0;
   logic cq[$];

   always #5 clk = ~clk;

   stb_sample_seq #(.CNT_WIDTH(CW), .TMO_WIDTH(TW), .SETTLE_CYCLES(SC)) dut (
      .clk_i      (clk),
      .arstn_i    (arstn_i),
      .start_i    (start_i),
      .n_samples_i(n_samples_i),
      .stb_rdy_i  (stb_rdy_i),
      .stb_valid_i(stb_valid_i),
      .stb_req_o  (stb_req_o),
      .cmp_i      (cmp_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .hits_o     (hits_o),
      .err_o      (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_t is the cycle index within the current strobe (0 = request low).
   int         m_left = 0, m_hits = 0, m_t = 0, m_sample_t = -1, m_hits_out = 0;
   bit         m_run = 0, m_done = 0, m_prev = 0, m_c1 = 0, m_c2 = 0;
   logic [1:0] m_err_out = ERR_OK;

   function automatic void fin(input int h, input logic [1:0] e);
      m_run = 0;
      m_done = 1;
      m_hits_out = h;
      m_err_out = e;
   endfunction

   initial forever begin
      @(posedge clk or negedge arstn_i);
      if (!arstn_i) begin
         m_run = 0; m_done = 0; m_prev = 0; m_c1 = 0; m_c2 = 0;
         m_hits = 0; m_hits_out = 0; m_err_out = ERR_OK; m_t = 0; m_sample_t = -1;
      end else begin
         if (m_done) m_done = 0;
         else if (!m_run) begin
            if (start_i) begin
               if (!stb_rdy_i) fin(0, ERR_NRDY);
               else if (n_samples_i == 0) fin(0, ERR_OK);
               else begin
                  m_run = 1; m_left = int'(n_samples_i); m_hits = 0; m_t = 0; m_sample_t = -1;
               end
            end
         end else if (m_sample_t < 0) begin
            if (m_t >= 2 && stb_valid_i && !m_prev) m_sample_t = m_t + SC + 1;
            else if (m_t == TMO_LIM + 1) fin(m_hits, ERR_TMO);
            m_t++;
         end else if (m_t == m_sample_t) begin
            m_hits += int'(m_c2);
            m_left--;
            if (m_left == 0) fin(m_hits, ERR_OK);
            else begin m_t = 0; m_sample_t = -1; end
         end else m_t++;
         m_prev = stb_valid_i;
         m_c2 = m_c1;
         m_c1 = cmp_i;
      end
   end

   initial forever begin
      @(negedge clk);
      if (arstn_i) begin
         chk("busy", busy_o, m_run || m_done);
         chk("done", done_o, m_done);
         chk("req", stb_req_o, m_run && m_t >= 1);
         chk("hits", hits_o, m_hits_out);
         chk("err", err_o, m_err_out);
      end
   end

   // Strobe generator / comparator stand-in.
   initial begin
      int vcnt = 0, hcnt = 0;
      bit rprev = 0;
      stb_valid_i = 1'b0;
      cmp_i = 1'b0;
      forever begin
         @(negedge clk);
         if (stb_req_o && !rprev) begin
            vcnt = (vdly > 0) ? vdly : int'($urandom_range(1, 12));
            if (cmode == 0 && cq.size() > 0) cmp_i = cq.pop_front();
         end
         rprev = stb_req_o;
         if (cmode == 1) cmp_i = 1'($urandom_range(0, 1));
         if (vmode == VM_SCHED) begin
            if (hcnt > 0) begin hcnt--; if (hcnt == 0) stb_valid_i = 1'b0; end
            if (vcnt > 0) begin vcnt--; if (vcnt == 0) begin stb_valid_i = 1'b1; hcnt = 2; end end
         end else begin
            vcnt = 0; hcnt = 0;
            stb_valid_i = (vmode == VM_LOW) ? 1'b0 : (vmode == VM_HIGH) ? 1'b1 : 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic run(input int n, input int max, output int cyc, output bit req_hi);
      @(negedge clk);
      start_i = 1'b1;
      n_samples_i = CW'(n);
      cyc = 0;
      req_hi = 0;
      do begin
         @(negedge clk);
         start_i = 1'b0;
         cyc++;
         req_hi |= stb_req_o;
      end while (!done_o && cyc < max);
      chk("done_seen", done_o, 1);
   endtask

   initial begin
      int cyc, rises;
      bit req_hi, rp, saw;
      #2 arstn_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_req", stb_req_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_hits", hits_o, 0);
      chk("rst_err", err_o, ERR_OK);
      arstn_i = 1'b1;
      stb_rdy_i = 1'b1;
      repeat (2) @(negedge clk);

      cq = '{1'b1, 1'b0, 1'b1};
      run(3, 200, cyc, req_hi);
      chk("three_hits", hits_o, 2);
      chk("three_err", err_o, ERR_OK);
      chk("three_cycles", cyc, 49);
      chk("three_req", req_hi, 1);

      run(0, 10, cyc, req_hi);
      chk("n0_cycles", cyc, 1);
      chk("n0_hits", hits_o, 0);
      chk("n0_err", err_o, ERR_OK);
      chk("n0_req", req_hi, 0);

      stb_rdy_i = 1'b0;
      run(5, 10, cyc, req_hi);
      chk("nrdy_cycles", cyc, 1);
      chk("nrdy_hits", hits_o, 0);
      chk("nrdy_err", err_o, ERR_NRDY);
      chk("nrdy_req", req_hi, 0);
      stb_rdy_i = 1'b1;

      vmode = VM_LOW;
      run(4, 100, cyc, req_hi);
      chk("tmo_cycles", cyc, 18);
      chk("tmo_err", err_o, ERR_TMO);
      chk("tmo_hits", hits_o, 0);

      vmode = VM_SCHED;
      vdly = 1;
      run(2, 100, cyc, req_hi);
      chk("early_valid_cycles", cyc, 18);
      chk("early_valid_err", err_o, ERR_TMO);

      vdly = 10;
      vmode = VM_HIGH;
      cq = '{1'b1};
      repeat (3) @(negedge clk);
      @(negedge clk);
      start_i = 1'b1;
      n_samples_i = CW'(1);
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      vmode = VM_LOW;
      repeat (2) @(negedge clk);
      vmode = VM_HIGH;
      cyc = 7;
      while (!done_o && cyc < 100) begin @(negedge clk); cyc++; end
      chk("held_done_seen", done_o, 1);
      chk("held_not_early", cyc >= 13, 1);
      chk("held_hits", hits_o, 1);
      chk("held_err", err_o, ERR_OK);
      vmode = VM_LOW;
      repeat (3) @(negedge clk);

      vmode = VM_SCHED;
      cq = '{1'b1, 1'b1, 1'b1};
      @(negedge clk);
      start_i = 1'b1;
      n_samples_i = CW'(3);
      rises = 0;
      rp = 0;
      for (int i = 0; i < 200 && rises < 2; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (stb_req_o && !rp) rises++;
         rp = stb_req_o;
      end
      chk("second_req_seen", rises, 2);
      repeat (11) @(negedge clk);
      arstn_i = 1'b0;
      #1;
      chk("abort_req", stb_req_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      chk("abort_hits", hits_o, 0);
      chk("abort_err", err_o, ERR_OK);
      repeat (3) @(negedge clk);
      arstn_i = 1'b1;
      saw = 0;
      repeat (20) begin @(negedge clk); saw |= done_o; end
      chk("abort_no_done", saw, 0);
      cq.delete();
      cq = '{1'b1, 1'b0};
      run(2, 200, cyc, req_hi);
      chk("rerun_hits", hits_o, 1);
      chk("rerun_err", err_o, ERR_OK);
      chk("rerun_cycles", cyc, 33);

      cmode = 1;
      vdly = 0;
      for (int s = 0; s < 6; s++) begin
         vmode = (s % 3 == 0) ? VM_SCHED : (s % 3 == 1) ? VM_RAND : ((s == 2) ? VM_LOW : VM_SCHED);
         repeat (500) begin
            @(negedge clk);
            start_i = ($urandom_range(0, 5) == 0);
            n_samples_i = CW'($urandom_range(0, 4));
            stb_rdy_i = ($urandom_range(0, 9) != 0);
         end
      end
      start_i = 1'b0;
      repeat (100) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
